// File: rtl/eth_tx_mux_framer.sv
// Ethernet TX framer: 14-byte dst/src/type header followed by payload from one of NUM_SRC byte FIFOs.
// Optional minimum-payload padding to 46 bytes is built when ETH_TX_PAD_EN is defined.
module eth_tx_mux_framer #(
    parameter int NUM_SRC    = 2,
    parameter int LEN_W      = 11,
    parameter int IFG_CYCLES = 12,
    localparam int SEL_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                     ethTXclock,
    input  logic                     reset_n,
    input  logic                     frameInfoLoad,
    input  logic [47:0]              srcMacAddr,
    input  logic [47:0]              dstMacAddr,
    input  logic [15:0]              etherType,
    input  logic [SEL_W+LEN_W-1:0]   fiFifoOut,
    input  logic                     fiFifoEmpty,
    output logic                     fiRdEn,
    input  logic [NUM_SRC*8-1:0]     dataFifoOut,
    input  logic [NUM_SRC-1:0]       dataFifoEmpty,
    output logic [NUM_SRC-1:0]       dataRdEn,
    input  logic                     TXack,
    output logic [7:0]               TXdata,
    output logic                     TXdataValid,
    output logic                     frameDone,
    output logic                     underrun,
    output logic                     badDesc,
    output logic                     busy
);

    localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ACK,
        S_HDR,
        S_PAYLOAD,
`ifdef ETH_TX_PAD_EN
        S_PAD,
`endif
        S_IFG
    } state_t;

    state_t             state_q, state_d;
    logic [47:0]        dst_q, dst_d, src_q, src_d;
    logic [15:0]        type_q, type_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [LEN_W-1:0]   len_q, len_d, cnt_q, cnt_d;
    logic [3:0]         idx_q, idx_d;
    logic [IFG_W-1:0]   ifg_q, ifg_d;
    logic [7:0]         txdata_q, txdata_d;
    logic               txvld_q, txvld_d, done_q, done_d, undr_q, undr_d, bad_q, bad_d;

    logic [SEL_W-1:0]   fi_sel;
    logic [LEN_W-1:0]   fi_len;
    logic [7:0]         head_byte;
    logic               head_empty, fi_rd, pop, fetch, finish;

    assign fi_sel = fiFifoOut[SEL_W+LEN_W-1 -: SEL_W];
    assign fi_len = fiFifoOut[LEN_W-1:0];

    function automatic logic [7:0] hdr_byte(input logic [111:0] h, input logic [3:0] k);
        int sh;
        sh = 8 * (13 - int'(k));
        return h[sh +: 8];
    endfunction

    always_comb begin
        head_byte  = 8'h00;
        head_empty = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel_q == SEL_W'(i)) begin
                head_byte  = dataFifoOut[8*i +: 8];
                head_empty = dataFifoEmpty[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        dst_d    = dst_q;
        src_d    = src_q;
        type_d   = type_q;
        sel_d    = sel_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        ifg_d    = ifg_q;
        txdata_d = txdata_q;
        txvld_d  = txvld_q;
        done_d   = 1'b0;
        undr_d   = 1'b0;
        bad_d    = 1'b0;
        fi_rd    = 1'b0;
        pop      = 1'b0;
        fetch    = 1'b0;
        finish   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frameInfoLoad) begin
                    dst_d  = dstMacAddr;
                    src_d  = srcMacAddr;
                    type_d = etherType;
                end
                if (!fiFifoEmpty) begin
                    fi_rd = 1'b1;
                    sel_d = fi_sel;
                    len_d = fi_len;
                    if (fi_len == '0 || 32'(fi_sel) >= 32'(NUM_SRC)) begin
                        bad_d = 1'b1;
                    end else begin
                        txvld_d  = 1'b1;
                        // A header load in the same cycle already owns the first byte.
                        txdata_d = frameInfoLoad ? dstMacAddr[47:40] : dst_q[47:40];
                        state_d  = S_WAIT_ACK;
                    end
                end
            end
            S_WAIT_ACK: begin
                if (TXack) begin
                    txdata_d = hdr_byte({dst_q, src_q, type_q}, 4'd1);
                    idx_d    = 4'd1;
                    state_d  = S_HDR;
                end
            end
            S_HDR: begin
                if (idx_q == 4'd13) begin
                    fetch   = 1'b1;
                    cnt_d   = len_q - 1'b1;
                    state_d = S_PAYLOAD;
                end else begin
                    txdata_d = hdr_byte({dst_q, src_q, type_q}, idx_q + 4'd1);
                    idx_d    = idx_q + 4'd1;
                end
            end
            S_PAYLOAD: begin
                // cnt_q holds the payload bytes still to be presented after the current one.
                if (cnt_q != '0) begin
                    fetch = 1'b1;
                    cnt_d = cnt_q - 1'b1;
                end
`ifdef ETH_TX_PAD_EN
                else if (len_q < LEN_W'(46)) begin
                    txdata_d = 8'h00;
                    cnt_d    = LEN_W'(46) - len_q - 1'b1;
                    state_d  = S_PAD;
                end
`endif
                else begin
                    finish = 1'b1;
                end
            end
`ifdef ETH_TX_PAD_EN
            S_PAD: begin
                if (cnt_q != '0) begin
                    txdata_d = 8'h00;
                    cnt_d    = cnt_q - 1'b1;
                end else begin
                    finish = 1'b1;
                end
            end
`endif
            S_IFG: begin
                if (ifg_q <= IFG_W'(1)) state_d = S_IDLE;
                else                    ifg_d   = ifg_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (fetch) begin
            pop      = !head_empty;
            txdata_d = head_empty ? 8'h00 : head_byte;
            undr_d   = head_empty;
        end
        if (finish) begin
            txvld_d  = 1'b0;
            txdata_d = 8'h00;
            done_d   = 1'b1;
            ifg_d    = IFG_W'(IFG_CYCLES);
            state_d  = (IFG_CYCLES == 0) ? S_IDLE : S_IFG;
        end
    end

    always_comb begin
        dataRdEn = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            dataRdEn[i] = pop && (sel_q == SEL_W'(i));
        end
    end

    // The pop strobe is combinational from IDLE, so hold it low while reset is applied.
    assign fiRdEn      = fi_rd & reset_n;
    assign TXdata      = txdata_q;
    assign TXdataValid = txvld_q;
    assign frameDone   = done_q;
    assign underrun    = undr_q;
    assign badDesc     = bad_q;
    assign busy        = (state_q != S_IDLE);

    always_ff @(posedge ethTXclock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            dst_q    <= '0;
            src_q    <= '0;
            type_q   <= '0;
            sel_q    <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            ifg_q    <= '0;
            txdata_q <= '0;
            txvld_q  <= 1'b0;
            done_q   <= 1'b0;
            undr_q   <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dst_q    <= dst_d;
            src_q    <= src_d;
            type_q   <= type_d;
            sel_q    <= sel_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            ifg_q    <= ifg_d;
            txdata_q <= txdata_d;
            txvld_q  <= txvld_d;
            done_q   <= done_d;
            undr_q   <= undr_d;
            bad_q    <= bad_d;
        end
    end

endmodule

// File: tb/tb_eth_tx_mux_framer.sv
// Directed bench for eth_tx_mux_framer: FWFT FIFO models, MAC ack responder and byte logger.
module tb_eth_tx_mux_framer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, frameInfoLoad;
    logic [47:0] src_mac, dst_mac;
    logic [15:0] etype;
    logic [11:0] fi_out;
    logic        fi_empty, fi_rd;
    logic [15:0] d_out;
    logic [1:0]  d_empty, d_rd;
    logic        TXack = 1'b0;
    logic [7:0]  txd;
    logic        txv, fdone, undr, bad, busy;

    logic [12:0] fi3_out;
    logic        fi3_empty, fi3_rd;
    logic [2:0]  d3_rd;
    logic [7:0]  txd3;
    logic        txv3, fdone3, undr3, bad3, busy3;

    eth_tx_mux_framer #(.NUM_SRC(2), .LEN_W(11), .IFG_CYCLES(12)) dut (
        .ethTXclock(clk), .reset_n(reset_n), .frameInfoLoad(frameInfoLoad),
        .srcMacAddr(src_mac), .dstMacAddr(dst_mac), .etherType(etype),
        .fiFifoOut(fi_out), .fiFifoEmpty(fi_empty), .fiRdEn(fi_rd),
        .dataFifoOut(d_out), .dataFifoEmpty(d_empty), .dataRdEn(d_rd),
        .TXack(TXack), .TXdata(txd), .TXdataValid(txv), .frameDone(fdone),
        .underrun(undr), .badDesc(bad), .busy(busy)
    );

    eth_tx_mux_framer #(.NUM_SRC(3), .LEN_W(11), .IFG_CYCLES(12)) dut3 (
        .ethTXclock(clk), .reset_n(reset_n), .frameInfoLoad(1'b0),
        .srcMacAddr(48'h0), .dstMacAddr(48'h0), .etherType(16'h0),
        .fiFifoOut(fi3_out), .fiFifoEmpty(fi3_empty), .fiRdEn(fi3_rd),
        .dataFifoOut(24'h0), .dataFifoEmpty(3'b111), .dataRdEn(d3_rd),
        .TXack(1'b0), .TXdata(txd3), .TXdataValid(txv3), .frameDone(fdone3),
        .underrun(undr3), .badDesc(bad3), .busy(busy3)
    );

    // FWFT FIFO models: writes from the stimulus, pops on the DUT read strobes.
    logic [11:0] desc_mem [64];
    logic [7:0]  mem0 [64];
    logic [7:0]  mem1 [64];
    int desc_wr = 0, desc_rd = 0, wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;

    assign fi_empty = (desc_rd == desc_wr);
    assign fi_out   = desc_mem[desc_rd & 63];
    assign d_empty  = {rd1 == wr1, rd0 == wr0};
    assign d_out    = {mem1[rd1 & 63], mem0[rd0 & 63]};

    always @(posedge clk) begin
        if (fi_rd)    desc_rd <= desc_rd + 1;
        if (d_rd[0])  rd0 <= rd0 + 1;
        if (d_rd[1])  rd1 <= rd1 + 1;
    end

    // Monitor: event counters, byte log (byte 0 logged once while held) and TXack responder.
    int n_undr = 0, n_bad = 0, n_fird = 0, n_done = 0, n_pop0 = 0, n_pop1 = 0;
    int n_multi = 0, n_vcyc = 0, low_cnt = 0, last_gap = -1, hcnt = 0, ack_delay = 0;
    bit prev_val = 1'b0, in_hold = 1'b0;
    logic [7:0] rxq [$];

    always @(negedge clk) begin
        if (undr)         n_undr  <= n_undr + 1;
        if (bad)          n_bad   <= n_bad + 1;
        if (fi_rd)        n_fird  <= n_fird + 1;
        if (fdone)        n_done  <= n_done + 1;
        if (d_rd[0])      n_pop0  <= n_pop0 + 1;
        if (d_rd[1])      n_pop1  <= n_pop1 + 1;
        if (d_rd == 2'b11) n_multi <= n_multi + 1;
        if (txv)          n_vcyc  <= n_vcyc + 1;
        if (!txv)         low_cnt <= low_cnt + 1;
        if (txv && !prev_val) begin
            last_gap <= low_cnt;
            low_cnt  <= 0;
        end
        if (!reset_n) begin
            prev_val <= 1'b0;
            in_hold  <= 1'b0;
            TXack    <= 1'b0;
            hcnt     <= 0;
        end else begin
            prev_val <= txv;
            if (txv) begin
                if (!prev_val) begin
                    rxq.push_back(txd);
                    in_hold <= 1'b1;
                    TXack   <= (ack_delay == 0);
                    hcnt    <= 1;
                end else if (in_hold) begin
                    if (TXack) begin
                        rxq.push_back(txd);
                        in_hold <= 1'b0;
                        TXack   <= 1'b0;
                    end else begin
                        TXack <= (hcnt == ack_delay);
                        hcnt  <= hcnt + 1;
                    end
                end else begin
                    rxq.push_back(txd);
                end
            end
        end
    end

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_desc(input logic sel, input logic [10:0] len);
        desc_mem[desc_wr & 63] = {sel, len};
        desc_wr++;
    endtask

    task automatic push0(input logic [7:0] b);
        mem0[wr0 & 63] = b;
        wr0++;
    endtask

    task automatic push1(input logic [7:0] b);
        mem1[wr1 & 63] = b;
        wr1++;
    endtask

    task automatic wait_done(input int target, input string tag);
        int k = 0;
        while (n_done < target && k < 400) begin
            tick(1);
            k++;
        end
        chk(tag, n_done >= target, 1);
        tick(2);
    endtask

    function automatic int flen(input int len);
`ifdef ETH_TX_PAD_EN
        return 14 + ((len < 46) ? 46 : len);
`else
        return 14 + len;
`endif
    endfunction

    logic [7:0] hdr_exp [14];
    int base, p0, p1, u, d, bd, fr, vc;

    initial begin
        hdr_exp = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F,
                    8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h08, 8'h00};
        reset_n = 1'b0;
        frameInfoLoad = 1'b0;
        dst_mac = 48'h0A0B0C0D0E0F;
        src_mac = 48'h111213141516;
        etype   = 16'h0800;
        fi3_out = {2'd3, 11'd5};
        fi3_empty = 1'b1;
        tick(3);
        chk("rst_valid", txv, 0);
        chk("rst_data", txd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", fdone, 0);
        reset_n = 1'b1;
        tick(2);
        frameInfoLoad = 1'b1;
        tick(1);
        frameInfoLoad = 1'b0;

        // Frame from source 1 with a late ack.
        for (int i = 0; i < 4; i++) push1(8'hA1 + 8'(i));
        ack_delay = 3;
        base = rxq.size(); p0 = n_pop0; p1 = n_pop1; u = n_undr; vc = n_vcyc;
        push_desc(1'b1, 11'd4);
        wait_done(1, "t1_done");
        chk("t1_len", rxq.size() - base, flen(4));
        chk("t1_vcyc", n_vcyc - vc, flen(4) + 3);
        for (int k = 0; k < 14; k++) chk("t1_hdr", rxq[base + k], hdr_exp[k]);
        for (int k = 0; k < 4; k++) chk("t1_pay", rxq[base + 14 + k], 8'hA1 + 8'(k));
        chk("t1_pop1", n_pop1 - p1, 4);
        chk("t1_pop0", n_pop0 - p0, 0);
        chk("t1_undr", n_undr - u, 0);

        // Underrun: source 0 has only two bytes for a four-byte payload.
        push0(8'hB1);
        push0(8'hB2);
        ack_delay = 0;
        base = rxq.size(); p0 = n_pop0; u = n_undr; d = n_done;
        push_desc(1'b0, 11'd4);
        wait_done(d + 1, "t2_done");
        chk("t2_len", rxq.size() - base, flen(4));
        chk("t2_b0", rxq[base + 14], 8'hB1);
        chk("t2_b1", rxq[base + 15], 8'hB2);
        chk("t2_b2", rxq[base + 16], 8'h00);
        chk("t2_b3", rxq[base + 17], 8'h00);
        chk("t2_undr", n_undr - u, 2);
        chk("t2_pop0", n_pop0 - p0, 2);

        // Zero-length descriptors are dropped.
        bd = n_bad; fr = n_fird; vc = n_vcyc;
        push_desc(1'b0, 11'd0);
        push_desc(1'b1, 11'd0);
        tick(30);
        chk("t3_bad", n_bad - bd, 2);
        chk("t3_fird", n_fird - fr, 2);
        chk("t3_vcyc", n_vcyc - vc, 0);
        chk("t3_busy", busy, 0);

        // Out-of-range source select on a three-source instance.
        fi3_empty = 1'b0;
        @(negedge clk);
        chk("t3_sel_fird", fi3_rd, 1);
        @(posedge clk);
        #1;
        fi3_empty = 1'b1;
        chk("t3_sel_bad", bad3, 1);
        chk("t3_sel_vld", txv3, 0);
        tick(1);
        chk("t3_sel_pulse", bad3, 0);

        // Two queued frames: inter-frame gap.
        for (int i = 0; i < 4; i++) push1(8'hC0 + 8'(i));
        base = rxq.size(); d = n_done;
        push_desc(1'b1, 11'd2);
        push_desc(1'b1, 11'd2);
        wait_done(d + 2, "t4_done");
        chk("t4_gap", last_gap, 13);
        chk("t4_len", rxq.size() - base, 2 * flen(2));
        chk("t4_f2_pay", rxq[base + flen(2) + 14], 8'hC2);

        // Short frame: padded only when the pad option is built.
        for (int i = 0; i < 10; i++) push1(8'h50 + 8'(i));
        base = rxq.size(); p1 = n_pop1; u = n_undr; d = n_done;
        push_desc(1'b1, 11'd10);
        wait_done(d + 1, "t5_done");
        chk("t5_len", rxq.size() - base, flen(10));
        chk("t5_first", rxq[base + 14], 8'h50);
        chk("t5_last", rxq[base + 23], 8'h59);
        chk("t5_tail", rxq[base + flen(10) - 1], (flen(10) > 24) ? 8'h00 : 8'h59);
        chk("t5_pop1", n_pop1 - p1, 10);
        chk("t5_undr", n_undr - u, 0);

        // Asynchronous reset in the middle of the payload.
        for (int i = 0; i < 20; i++) push1(8'h60 + 8'(i));
        base = rxq.size();
        push_desc(1'b1, 11'd20);
        begin
            int k = 0;
            while (rxq.size() < base + 18 && k < 200) begin
                tick(1);
                k++;
            end
            chk("t6_reach_payload", rxq.size() >= base + 18, 1);
        end
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_vld", txv, 0);
        chk("t6_rst_rden", d_rd, 0);
        chk("t6_rst_busy", busy, 0);
        tick(2);
        reset_n = 1'b1;
        tick(2);
        push0(8'hD1);
        push0(8'hD2);
        push0(8'hD3);
        base = rxq.size(); u = n_undr; d = n_done;
        push_desc(1'b0, 11'd3);
        wait_done(d + 1, "t6_done");
        chk("t6_len", rxq.size() - base, flen(3));
        chk("t6_hdr0", rxq[base], 8'h00);
        chk("t6_hdr13", rxq[base + 13], 8'h00);
        for (int k = 0; k < 3; k++) chk("t6_pay", rxq[base + 14 + k], 8'hD1 + 8'(k));
        chk("t6_undr", n_undr - u, 0);

        chk("onehot_rden", n_multi, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
